// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: Moore control sequencer for the shared-resource multicycle RV32I datapath
module multicycle_ctrl_fsm #(
   parameter bit USE_MEM_READY = 1'b1,
   parameter int STATE_W       = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         op,
   input  logic               Zero,
   input  logic               MemReady,
   output logic               MemReq,
   output logic               AdrSrc,
   output logic               IRWrite,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ImmSrc,
   output logic               RegWrite,
   output logic               MemWrite,
   output logic               PCWrite,
   output logic               Illegal,
   output logic [STATE_W-1:0] State
);
   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = 0,
      S_DECODE   = 1,
      S_MEMADR   = 2,
      S_MEMREAD  = 3,
      S_MEMWB    = 4,
      S_MEMWRITE = 5,
      S_EXECUTER = 6,
      S_EXECUTEI = 7,
      S_ALUWB    = 8,
      S_BEQ      = 9,
      S_JAL      = 10,
      S_ILLEGAL  = 11
   } state_t;

   state_t     r_state, w_next;
   logic       r_memreq, r_adrsrc, r_fetch, r_regwrite, r_memwrite, r_pcupdate, r_branch, r_illegal;
   logic [1:0] r_alusrca, r_alusrcb, r_aluop, r_resultsrc;
   logic       w_memreq, w_adrsrc, w_fetch, w_regwrite, w_memwrite, w_pcupdate, w_branch, w_illegal;
   logic [1:0] w_alusrca, w_alusrcb, w_aluop, w_resultsrc;
   logic       w_ready;

   assign w_ready = USE_MEM_READY ? MemReady : 1'b1;

   // next-state: memory states stall on w_ready, DECODE dispatches on opcode, stray codes recover to FETCH
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
         S_DECODE:
            case (op)
               7'b0000011, 7'b0100011: w_next = S_MEMADR;
               7'b0110011:             w_next = S_EXECUTER;
               7'b0010011:             w_next = S_EXECUTEI;
               7'b1100011:             w_next = S_BEQ;
               7'b1101111:             w_next = S_JAL;
               default:                w_next = S_ILLEGAL;
            endcase
         S_MEMADR:   w_next = (op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
         S_MEMWB:    w_next = S_FETCH;
         S_EXECUTER, S_EXECUTEI, S_JAL: w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   // Moore output table for the state being entered, so outputs come straight from flops
   always_comb begin
      w_memreq    = 1'b0;
      w_adrsrc    = 1'b0;
      w_fetch     = 1'b0;
      w_alusrca   = 2'b00;
      w_alusrcb   = 2'b00;
      w_aluop     = 2'b00;
      w_resultsrc = 2'b00;
      w_regwrite  = 1'b0;
      w_memwrite  = 1'b0;
      w_pcupdate  = 1'b0;
      w_branch    = 1'b0;
      w_illegal   = 1'b0;
      case (w_next)
         S_FETCH: begin
            w_memreq    = 1'b1;
            w_fetch     = 1'b1;
            w_alusrcb   = 2'b10;
            w_resultsrc = 2'b10;
         end
         S_DECODE: begin
            w_alusrca = 2'b01;
            w_alusrcb = 2'b01;
         end
         S_MEMADR: begin
            w_alusrca = 2'b10;
            w_alusrcb = 2'b01;
         end
         S_MEMREAD: begin
            w_memreq = 1'b1;
            w_adrsrc = 1'b1;
         end
         S_MEMWB: begin
            w_resultsrc = 2'b01;
            w_regwrite  = 1'b1;
         end
         S_MEMWRITE: begin
            w_memreq   = 1'b1;
            w_adrsrc   = 1'b1;
            w_memwrite = 1'b1;
         end
         S_EXECUTER: begin
            w_alusrca = 2'b10;
            w_aluop   = 2'b10;
         end
         S_EXECUTEI: begin
            w_alusrca = 2'b10;
            w_alusrcb = 2'b01;
            w_aluop   = 2'b10;
         end
         S_ALUWB:   w_regwrite = 1'b1;
         S_BEQ: begin
            w_alusrca = 2'b10;
            w_aluop   = 2'b01;
            w_branch  = 1'b1;
         end
         S_JAL: begin
            w_alusrca  = 2'b01;
            w_alusrcb  = 2'b10;
            w_pcupdate = 1'b1;
         end
         S_ILLEGAL: w_illegal = 1'b1;
         default:   w_illegal = 1'b0;
      endcase
   end

   // state and registered Moore outputs; reset lands on FETCH values immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_FETCH;
         r_memreq    <= 1'b1;
         r_adrsrc    <= 1'b0;
         r_fetch     <= 1'b1;
         r_alusrca   <= 2'b00;
         r_alusrcb   <= 2'b10;
         r_aluop     <= 2'b00;
         r_resultsrc <= 2'b10;
         r_regwrite  <= 1'b0;
         r_memwrite  <= 1'b0;
         r_pcupdate  <= 1'b0;
         r_branch    <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_memreq    <= w_memreq;
         r_adrsrc    <= w_adrsrc;
         r_fetch     <= w_fetch;
         r_alusrca   <= w_alusrca;
         r_alusrcb   <= w_alusrcb;
         r_aluop     <= w_aluop;
         r_resultsrc <= w_resultsrc;
         r_regwrite  <= w_regwrite;
         r_memwrite  <= w_memwrite;
         r_pcupdate  <= w_pcupdate;
         r_branch    <= w_branch;
         r_illegal   <= w_illegal;
      end
   end

   assign State     = r_state;
   assign AdrSrc    = r_adrsrc;
   assign ALUSrcA   = r_alusrca;
   assign ALUSrcB   = r_alusrcb;
   assign ALUOp     = r_aluop;
   assign ResultSrc = r_resultsrc;
   assign MemReq    = r_memreq & ~reset;
   assign IRWrite   = r_fetch & w_ready & ~reset;
   assign RegWrite  = r_regwrite & ~reset;
   assign MemWrite  = r_memwrite & ~reset;
   assign Illegal   = r_illegal & ~reset;
   assign PCWrite   = ~reset & ((r_fetch & w_ready) | r_pcupdate | (r_branch & Zero));
   assign ImmSrc    = (op == 7'b0100011) ? 2'b01 :
                      (op == 7'b1100011) ? 2'b10 :
                      (op == 7'b1101111) ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed instruction sequences with a per-cycle scoreboard
module tb_multicycle_ctrl_fsm;
   logic       clk, reset, Zero, MemReady;
   logic [6:0] op;
   logic       MemReq, AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite, Illegal;
   logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc;
   logic [3:0] State;

   typedef struct packed {
      logic [6:0] op;
      logic       mr, z, rst;
      logic [3:0] st;
   } item_t;

   item_t q[$];
   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                          IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

   multicycle_ctrl_fsm #(.USE_MEM_READY(1'b1), .STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .Zero(Zero), .MemReady(MemReady),
      .MemReq(MemReq), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .PCWrite(PCWrite), .Illegal(Illegal),
      .State(State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected control word for a state, from the per-state output table
   function automatic logic [20:0] expect_word(input item_t it);
      logic [3:0] s;
      logic       en, memreq, adrsrc, irw, rw, mw, pcw, ill;
      logic [1:0] sa, sb, ao, rs, imm;
      s      = it.st;
      en     = ~it.rst;
      memreq = en & (s == 0 || s == 3 || s == 5);
      adrsrc = (s == 3 || s == 5);
      irw    = en & (s == 0) & it.mr;
      sa     = (s == 1 || s == 10) ? 2'b01 : (s == 2 || s == 6 || s == 7 || s == 9) ? 2'b10 : 2'b00;
      sb     = (s == 0 || s == 10) ? 2'b10 : (s == 1 || s == 2 || s == 7) ? 2'b01 : 2'b00;
      ao     = (s == 6 || s == 7) ? 2'b10 : (s == 9) ? 2'b01 : 2'b00;
      rs     = (s == 0) ? 2'b10 : (s == 4) ? 2'b01 : 2'b00;
      imm    = (it.op == SW) ? 2'b01 : (it.op == BQ) ? 2'b10 : (it.op == JL) ? 2'b11 : 2'b00;
      rw     = en & (s == 4 || s == 8);
      mw     = en & (s == 5);
      pcw    = en & ((s == 0 && it.mr) || s == 10 || (s == 9 && it.z));
      ill    = en & (s == 11);
      return {s, memreq, adrsrc, irw, sa, sb, ao, rs, imm, rw, mw, pcw, ill};
   endfunction

   // monitor: one scoreboard entry is checked per cycle, away from the rising edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         item_t it;
         logic [20:0] got, exp;
         it  = q.pop_front();
         exp = expect_word(it);
         got = {State, MemReq, AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc,
                RegWrite, MemWrite, PCWrite, Illegal};
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL ctrl_word t=%0t op=%b st=%0d got=%h required=%h", $time, it.op, it.st, got, exp);
         end
      end
   end

   task automatic cyc(input logic [6:0] o, input logic mr, input logic z, input logic r, input logic [3:0] st);
      @(posedge clk);
      #1;
      op       = o;
      MemReady = mr;
      Zero     = z;
      reset    = r;
      q.push_back('{op: o, mr: mr, z: z, rst: r, st: st});
   endtask

   initial begin
      reset = 1'b1; op = 7'b0; MemReady = 1'b1; Zero = 1'b0;
      cyc(LW, 1, 0, 1, 0);
      cyc(LW, 1, 0, 1, 0);
      // lw, ideal memory
      cyc(LW, 1, 0, 0, 0); cyc(LW, 1, 0, 0, 1); cyc(LW, 1, 0, 0, 2); cyc(LW, 1, 0, 0, 3); cyc(LW, 1, 0, 0, 4);
      // sw with three wait cycles in MEMWRITE
      cyc(SW, 1, 0, 0, 0); cyc(SW, 1, 0, 0, 1); cyc(SW, 1, 0, 0, 2);
      cyc(SW, 0, 0, 0, 5); cyc(SW, 0, 0, 0, 5); cyc(SW, 0, 0, 0, 5); cyc(SW, 1, 0, 0, 5);
      // beq taken, then not taken
      cyc(BQ, 1, 0, 0, 0); cyc(BQ, 1, 0, 0, 1); cyc(BQ, 1, 1, 0, 9);
      cyc(BQ, 1, 0, 0, 0); cyc(BQ, 1, 1, 0, 1); cyc(BQ, 1, 0, 0, 9);
      // jal
      cyc(JL, 1, 0, 0, 0); cyc(JL, 1, 0, 0, 1); cyc(JL, 1, 0, 0, 10); cyc(JL, 1, 0, 0, 8);
      // illegal opcode
      cyc(BAD, 1, 0, 0, 0); cyc(BAD, 1, 0, 0, 1); cyc(BAD, 1, 0, 0, 11);
      // R-type and I-type
      cyc(RT, 1, 0, 0, 0); cyc(RT, 1, 0, 0, 1); cyc(RT, 1, 0, 0, 6); cyc(RT, 1, 0, 0, 8);
      cyc(IT, 1, 0, 0, 0); cyc(IT, 1, 0, 0, 1); cyc(IT, 1, 0, 0, 7); cyc(IT, 1, 0, 0, 8);
      // lw with FETCH and MEMREAD waits
      cyc(LW, 0, 0, 0, 0); cyc(LW, 1, 0, 0, 0); cyc(LW, 1, 0, 0, 1); cyc(LW, 1, 0, 0, 2);
      cyc(LW, 0, 0, 0, 3); cyc(LW, 1, 0, 0, 3); cyc(LW, 1, 0, 0, 4);
      // reset while parked in MEMREAD, then a clean fetch afterwards
      cyc(LW, 1, 0, 0, 0); cyc(LW, 1, 0, 0, 1); cyc(LW, 1, 0, 0, 2); cyc(LW, 0, 0, 0, 3);
      cyc(LW, 1, 0, 1, 0);
      cyc(BAD, 1, 0, 0, 0); cyc(BAD, 1, 0, 0, 1); cyc(BAD, 1, 0, 0, 11); cyc(BAD, 1, 0, 0, 0);
      repeat (3) @(negedge clk);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain left=%0d required=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout t=%0t required=finish", $time);
      $fatal(1, "timeout");
   end
endmodule
